regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port (RD/PD/EN) between two writers: pipeline
//  writeback (WB, high priority, no backpressure) and the multi-cycle unit (MU, valid/ready).
//  MU results wait in a small FIFO and drain on cycles WB leaves the port free. A starvation
//  limit forces a drain and stalls WB. PEND reports queued destinations to decode hazard logic.
// PARAMETERS
//  DW          32  write data width
//  AW          5   register address width (32 registers)
//  DEPTH       2   MU FIFO entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive WB-blocked cycles before a forced FIFO drain
// PORTS
//  CLK       in   1      clock; all state updates on rising edge
//  RST       in   1      asynchronous reset, active-high
//  WB_EN     in   1      writeback request this cycle
//  WB_RD     in   AW     writeback destination register
//  WB_PD     in   DW     writeback data
//  WB_STALL  out  1      WB not granted; pipeline holds WB_EN/WB_RD/WB_PD stable
//  MU_VALID  in   1      MU result valid
//  MU_RD     in   AW     MU destination register
//  MU_PD     in   DW     MU result data
//  MU_READY  out  1      FIFO can accept; transfer = MU_VALID & MU_READY
//  RF_EN     out  1      register file write enable (drives EN)
//  RF_RD     out  AW     register file write address (drives RD)
//  RF_PD     out  DW     register file write data (drives PD)
//  PEND      out  2**AW  bit i = a queued FIFO entry targets register i
// BEHAVIOUR
//  - Reset (async): FIFO empty, pointers/count = 0, starve counter = 0. While RST is high,
//    RF_EN = 0, WB_STALL = 0, MU_READY = 0, PEND = 0.
//  - MU_READY = (count < DEPTH), from registered count only; a same-cycle pop does not raise it.
//  - Push: transfer with MU_RD != 0 stores {MU_RD, MU_PD} at the tail. A transfer with MU_RD == 0
//    is accepted and discarded (R0 is hardwired zero).
//  - A WB request with WB_RD == 0 is treated as no request and never stalls.
//  - Arbitration, combinational per cycle (wb_req = WB_EN & WB_RD != 0):
//      force  = wb_req & !empty & (starve == STARVE_MAX)
//      wb_req & !force   -> RF_* = WB_*, RF_EN = 1, WB_STALL = 0
//      force             -> RF_* = FIFO head, pop, RF_EN = 1, WB_STALL = 1
//      !wb_req & !empty  -> RF_* = FIFO head, pop, RF_EN = 1
//      else              -> RF_EN = 0 (RF_RD/RF_PD don't-care, drive 0)
//  - Latency: WB to RF port is 0 cycles. MU push to earliest RF write is 1 cycle; no bypass of
//    an empty FIFO.
//  - Starve counter: +1 on a cycle with !empty & wb_req & !force; cleared on any pop; cleared
//    when empty. Saturates at STARVE_MAX.
//  - Simultaneous push and pop: both happen; count unchanged. Push while full is impossible
//    (MU_READY = 0).
//  - Pointers wrap modulo DEPTH. count has width clog2(DEPTH)+1.
//  - PEND: OR over valid entries of one-hot(rd). Combinational from storage, so an entry popped
//    this cycle still shows in PEND this cycle.
//  - Ordering: FIFO entries drain in push order. WB/MU ordering to the same register is decode's
//    job: decode must stall any instruction whose RA, RB or RD bit is set in PEND. This block
//    never reorders or merges writes.
//  - RST asserted mid-operation discards queued entries. A stall is released immediately.
// STRUCTURE
//  - Shared header modules/regfile_defs.vh: `RF_DW (32), `RF_AW (5), `RF_NREG (32), `RF_R0 (0).
//    The register file, this block and decode hazard logic all use these.
//  - Sub-module regfile_wr_fifo: sync FIFO, {AW+DW} wide, DEPTH deep, with push/pop/full/empty,
//    head output and per-entry valid+rd export for PEND.
//  - Top level: arbitration logic, starve counter, PEND reduction.
// TESTING
//  1 WB only: WB_EN=1, WB_RD=5, WB_PD=32'hDEADBEEF -> same cycle RF_EN=1, RF_RD=5,
//    RF_PD=DEADBEEF, WB_STALL=0.
//  2 MU idle drain: push {7, 32'h12345678} with WB_EN=0 -> next cycle RF_EN=1, RF_RD=7,
//    PEND[7] 1 then 0.
//  3 Full: 2 pushes with WB busy -> MU_READY=0; third MU_VALID held until a pop; entries drain
//    in order {3,A},{4,B}.
//  4 Starvation: 1 entry queued, WB_EN=1 (RD=9) continuously -> 4 WB grants, then 1 cycle
//    WB_STALL=1 with FIFO write; WB RD=9 granted the next cycle.
//  5 R0: MU push RD=0 -> accepted, no RF write, PEND=0; WB_EN=1 RD=0 with FIFO non-empty ->
//    FIFO drains, WB_STALL=0.
//  6 Async reset with 2 entries queued, mid-stall -> RF_EN=0, WB_STALL=0, PEND=0 immediately;
//    after release MU_READY=1, nothing drains.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file geometry and the write-port grant encoding used by the arbiter.
package regfile_write_arbiter_pkg;

  localparam int RF_DW   = 32;
  localparam int RF_AW   = 5;
  localparam int RF_NREG = 32;
  localparam int RF_R0   = 0;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_WB    = 2'd1,
    GNT_FIFO  = 2'd2,
    GNT_FORCE = 2'd3
  } gnt_e;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Synchronous FIFO for queued MU writes; exports per-entry valid and destination for hazard reporting.
module regfile_wr_fifo #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [AW+DW-1:0]       i_data,
  input  logic                   i_pop,
  output logic [AW+DW-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [DEPTH-1:0]       o_vld,
  output logic [DEPTH*AW-1:0]    o_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_vld   = r_vld;

  always_comb begin
    o_rd = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      o_rd[i*AW +: AW] = r_mem[i][AW+DW-1:DW];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and queued MU results,
// with a starvation limit that forces a FIFO drain and stalls writeback.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DW         = RF_DW,
  parameter int AW         = RF_AW,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WB_EN,
  input  logic [AW-1:0]     WB_RD,
  input  logic [DW-1:0]     WB_PD,
  output logic              WB_STALL,
  input  logic              MU_VALID,
  input  logic [AW-1:0]     MU_RD,
  input  logic [DW-1:0]     MU_PD,
  output logic              MU_READY,
  output logic              RF_EN,
  output logic [AW-1:0]     RF_RD,
  output logic [DW-1:0]     RF_PD,
  output logic [2**AW-1:0]  PEND
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [AW+DW-1:0]    w_head;
  logic                w_full;
  logic                w_empty;
  logic [DEPTH-1:0]    w_vld;
  logic [DEPTH*AW-1:0] w_rd;
  logic                w_wb_req;
  logic                w_force;
  logic                w_push;
  logic                w_pop;
  logic [2**AW-1:0]    w_pend;
  gnt_e                w_gnt;
  logic [SW-1:0]       r_starve;

  assign w_wb_req = WB_EN & (WB_RD != AW'(RF_R0));
  assign w_force  = w_wb_req & ~w_empty & (r_starve == STARVE_LIM);
  // R0 transfers complete the handshake but never enter the queue.
  assign w_push   = MU_VALID & MU_READY & (MU_RD != AW'(RF_R0));
  assign w_pop    = (w_gnt == GNT_FIFO) | (w_gnt == GNT_FORCE);

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_force)       w_gnt = GNT_FORCE;
    else if (w_wb_req) w_gnt = GNT_WB;
    else if (!w_empty) w_gnt = GNT_FIFO;
  end

  regfile_wr_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  ({MU_RD, MU_PD}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_vld   (w_vld),
    .o_rd    (w_rd)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_starve <= '0;
    else if (w_pop || w_empty)
      r_starve <= '0;
    else if ((w_gnt == GNT_WB) && (r_starve != STARVE_LIM))
      r_starve <= r_starve + 1'b1;
  end

  always_comb begin
    w_pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (w_vld[i]) w_pend[w_rd[i*AW +: AW]] = 1'b1;
  end

  always_comb begin
    RF_EN = 1'b0;
    RF_RD = '0;
    RF_PD = '0;
    unique case (w_gnt)
      GNT_WB: begin
        RF_EN = 1'b1;
        RF_RD = WB_RD;
        RF_PD = WB_PD;
      end
      GNT_FIFO, GNT_FORCE: begin
        RF_EN = 1'b1;
        RF_RD = w_head[AW+DW-1:DW];
        RF_PD = w_head[DW-1:0];
      end
      default: ;
    endcase
    if (RST) RF_EN = 1'b0;
  end

  assign WB_STALL = ~RST & (w_gnt == GNT_FORCE);
  assign MU_READY = ~RST & ~w_full;
  assign PEND     = RST ? '0 : w_pend;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for the register-file write-port arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WB_EN;
  logic [4:0]  WB_RD;
  logic [31:0] WB_PD;
  logic        WB_STALL;
  logic        MU_VALID;
  logic [4:0]  MU_RD;
  logic [31:0] MU_PD;
  logic        MU_READY;
  logic        RF_EN;
  logic [4:0]  RF_RD;
  logic [31:0] RF_PD;
  logic [31:0] PEND;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 CLK = ~CLK;

  regfile_write_arbiter #(
    .DW         (32),
    .AW         (5),
    .DEPTH      (2),
    .STARVE_MAX (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WB_EN    (WB_EN),
    .WB_RD    (WB_RD),
    .WB_PD    (WB_PD),
    .WB_STALL (WB_STALL),
    .MU_VALID (MU_VALID),
    .MU_RD    (MU_RD),
    .MU_PD    (MU_PD),
    .MU_READY (MU_READY),
    .RF_EN    (RF_EN),
    .RF_RD    (RF_RD),
    .RF_PD    (RF_PD),
    .PEND     (PEND)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge, then let combinational outputs settle.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] pd);
    WB_EN = en; WB_RD = rd; WB_PD = pd;
  endtask

  task automatic mu(input logic v, input logic [4:0] rd, input logic [31:0] pd);
    MU_VALID = v; MU_RD = rd; MU_PD = pd;
  endtask

  initial begin
    RST = 1'b1;
    wb(1'b1, 5'd3, 32'h1);
    mu(1'b0, 5'd0, 32'h0);
    #3;
    check("rst_rf_en", RF_EN, 0);
    check("rst_stall", WB_STALL, 0);
    check("rst_ready", MU_READY, 0);
    check("rst_pend", PEND, 0);
    cyc(); cyc();
    RST = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    settle();
    check("idle_ready", MU_READY, 1);
    check("idle_rf_en", RF_EN, 0);

    // 1: WB passes straight through
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    settle();
    check("t1_en", RF_EN, 1);
    check("t1_rd", RF_RD, 5);
    check("t1_pd", RF_PD, 32'hDEADBEEF);
    check("t1_stall", WB_STALL, 0);
    cyc();
    wb(1'b0, 5'd0, 32'h0);

    // 2: MU push drains the following cycle, no bypass
    mu(1'b1, 5'd7, 32'h12345678);
    settle();
    check("t2_ready", MU_READY, 1);
    check("t2_nobypass", RF_EN, 0);
    cyc();
    mu(1'b0, 5'd0, 32'h0);
    settle();
    check("t2_en", RF_EN, 1);
    check("t2_rd", RF_RD, 7);
    check("t2_pd", RF_PD, 32'h12345678);
    check("t2_pend", PEND, 64'h80);
    cyc();
    settle();
    check("t2_pend_clr", PEND, 0);
    check("t2_idle", RF_EN, 0);

    // 3: fill FIFO under WB traffic, hold third MU result, drain in order
    wb(1'b1, 5'd1, 32'h111);
    mu(1'b1, 5'd3, 32'hA);
    settle();
    check("t3_wb0", RF_RD, 1);
    cyc();
    mu(1'b1, 5'd4, 32'hB);
    settle();
    check("t3_ready1", MU_READY, 1);
    check("t3_wb1", RF_RD, 1);
    cyc();
    mu(1'b1, 5'd5, 32'hC);
    wb(1'b0, 5'd0, 32'h0);
    settle();
    check("t3_full", MU_READY, 0);
    check("t3_pend2", PEND, 64'h18);
    check("t3_d0_rd", RF_RD, 3);
    check("t3_d0_pd", RF_PD, 32'hA);
    cyc();
    settle();
    check("t3_ready2", MU_READY, 1);
    check("t3_d1_rd", RF_RD, 4);
    check("t3_d1_pd", RF_PD, 32'hB);
    check("t3_pend1", PEND, 64'h10);
    cyc();
    mu(1'b0, 5'd0, 32'h0);
    settle();
    check("t3_d2_rd", RF_RD, 5);
    check("t3_d2_pd", RF_PD, 32'hC);
    cyc();
    settle();
    check("t3_empty", RF_EN, 0);
    check("t3_pend0", PEND, 0);

    // 4: starvation forces one drain after four WB grants with a non-empty FIFO
    wb(1'b1, 5'd9, 32'h99);
    mu(1'b1, 5'd6, 32'h66);
    settle();
    check("t4_push_wb", RF_RD, 9);
    cyc();
    mu(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("t4_grant%0d_rd", k), RF_RD, 9);
      check($sformatf("t4_grant%0d_stall", k), WB_STALL, 0);
      cyc();
    end
    settle();
    check("t4_force_stall", WB_STALL, 1);
    check("t4_force_en", RF_EN, 1);
    check("t4_force_rd", RF_RD, 6);
    check("t4_force_pd", RF_PD, 32'h66);
    cyc();
    settle();
    check("t4_after_stall", WB_STALL, 0);
    check("t4_after_rd", RF_RD, 9);
    check("t4_after_pend", PEND, 0);
    cyc();
    wb(1'b0, 5'd0, 32'h0);

    // 5: R0 handling on both sides
    mu(1'b1, 5'd0, 32'hFF);
    settle();
    check("t5_r0_ready", MU_READY, 1);
    cyc();
    mu(1'b0, 5'd0, 32'h0);
    settle();
    check("t5_r0_noen", RF_EN, 0);
    check("t5_r0_pend", PEND, 0);
    wb(1'b1, 5'd2, 32'h22);
    mu(1'b1, 5'd8, 32'h88);
    cyc();
    wb(1'b1, 5'd0, 32'h0);
    mu(1'b0, 5'd0, 32'h0);
    settle();
    check("t5_wbr0_en", RF_EN, 1);
    check("t5_wbr0_rd", RF_RD, 8);
    check("t5_wbr0_stall", WB_STALL, 0);
    cyc();
    settle();
    check("t5_wbr0_idle", RF_EN, 0);
    wb(1'b0, 5'd0, 32'h0);
    cyc();

    // 6: async reset during a forced drain with two entries queued
    wb(1'b1, 5'd9, 32'h99);
    mu(1'b1, 5'd10, 32'hA0);
    cyc();
    mu(1'b1, 5'd11, 32'hB1);
    cyc();
    mu(1'b0, 5'd0, 32'h0);
    cyc(); cyc(); cyc();
    settle();
    check("t6_stall", WB_STALL, 1);
    check("t6_pend", PEND, 64'hC00);
    #1;
    RST = 1'b1;
    #1;
    check("t6_rst_en", RF_EN, 0);
    check("t6_rst_stall", WB_STALL, 0);
    check("t6_rst_pend", PEND, 0);
    check("t6_rst_ready", MU_READY, 0);
    cyc();
    RST = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    settle();
    check("t6_rel_ready", MU_READY, 1);
    check("t6_rel_en", RF_EN, 0);
    check("t6_rel_pend", PEND, 0);
    cyc();
    settle();
    check("t6_rel_en2", RF_EN, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
